// File: rtl/matmul_seq_controller.sv
// Sequencing controller for a time-multiplexed float32 matrix product C = A * B.
// It runs one MAC per clock through an external multiplier and an external adder.
module matmul_seq_controller #(
    parameter int L = 2,
    parameter int M = 2,
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [32*L*M-1:0] A,
    input  logic [32*N*M-1:0] B_T,
    output logic              busy,
    output logic              done,
    output logic [32*L*N-1:0] result,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_result,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    input  logic [31:0]       add_result
);

    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (M > 1) ? $clog2(M) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(L - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [IW-1:0]       i;
    logic [JW-1:0]       j;
    logic [KW-1:0]       k;
    logic [31:0]         acc;
    logic [32*L*M-1:0]   a_q;
    logic [32*N*M-1:0]   b_q;
    int unsigned         a_idx;
    int unsigned         b_idx;
    int unsigned         c_idx;

    // Operands always come from the latched copies, so they stay defined outside MAC too.
    always_comb begin
        a_idx = 32'(i) * 32'(M) + 32'(k);
        b_idx = 32'(j) * 32'(M) + 32'(k);
        c_idx = 32'(i) * 32'(N) + 32'(j);
        mul_a = a_q[32*a_idx +: 32];
        mul_b = b_q[32*b_idx +: 32];
        add_a = acc;
        add_b = mul_result;
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B_T;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (k == K_LAST) begin
                        // Element finished: commit the sum and restart the accumulator at +0.0.
                        result[32*c_idx +: 32] <= add_result;
                        acc <= '0;
                        k   <= '0;
                        if (j == J_LAST) begin
                            j <= '0;
                            if (i == I_LAST) begin
                                i     <= '0;
                                state <= S_DONE;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        acc <= add_result;
                        k   <= k + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_controller.sv
// Directed bench for matmul_seq_controller: a 2x2x2 instance and a 1x3x2 instance.
// The external units are integer multiply/add stand-ins so sums are exact and hand-checkable.
module tb_matmul_seq_controller;

    logic clk;
    logic rst;

    logic          start0;
    logic [127:0]  a0;
    logic [127:0]  b0;
    logic          busy0;
    logic          done0;
    logic [127:0]  res0;
    logic [31:0]   mul_a0, mul_b0, mul_res0, add_a0, add_b0, add_res0;

    logic          start1;
    logic [95:0]   a1;
    logic [191:0]  b1;
    logic          busy1;
    logic          done1;
    logic [63:0]   res1;
    logic [31:0]   mul_a1, mul_b1, mul_res1, add_a1, add_b1, add_res1;

    int checks;
    int errors;

    matmul_seq_controller #(.L(2), .M(2), .N(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B_T(b0),
        .busy(busy0), .done(done0), .result(res0),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_result(mul_res0),
        .add_a(add_a0), .add_b(add_b0), .add_result(add_res0)
    );

    matmul_seq_controller #(.L(1), .M(3), .N(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B_T(b1),
        .busy(busy1), .done(done1), .result(res1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_result(mul_res1),
        .add_a(add_a1), .add_b(add_b1), .add_result(add_res1)
    );

    assign mul_res0 = mul_a0 * mul_b0;
    assign add_res0 = add_a0 + add_b0;
    assign mul_res1 = mul_a1 * mul_b1;
    assign add_res1 = add_a1 + add_b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A(i,k) at word i*M+k, B_T(j,k) at word j*M+k, C(i,j) at word i*N+j.
    localparam logic [127:0] A_1 = {32'd4, 32'd2, 32'd1, 32'd3};
    localparam logic [127:0] B_1 = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [127:0] C_1 = {32'd46, 32'd34, 32'd29, 32'd21};
    localparam logic [127:0] A_2 = {32'hFFFFFFFD, 32'd0, 32'd2, 32'hFFFFFFFF};
    localparam logic [127:0] B_2 = {32'hFFFFFFFE, 32'd10, 32'd1, 32'd1};
    localparam logic [127:0] C_2 = {32'd6, 32'hFFFFFFFD, 32'hFFFFFFF2, 32'd1};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One job on dut0; n counts negedges after the accepting edge.
    task automatic run_job(input string tag, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] exp, input bit poke, input bit scramble);
        @(negedge clk);
        a0 = a;
        b0 = b;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        if (scramble) begin
            a0 = ~a;
            b0 = ~b;
        end
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            start0 = poke && (n == 2 || n == 3);
            check({tag, ".busy"}, busy0, (n <= 8) ? 128'd1 : 128'd0);
            check({tag, ".done"}, done0, (n == 8) ? 128'd1 : 128'd0);
            if (n == 8) check({tag, ".result"}, res0, exp);
        end
        start0 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        a0 = '0;
        b0 = '0;
        a1 = '0;
        b1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.busy", busy0, 128'd0);
        check("rst.done", done0, 128'd0);
        check("rst.result", res0, 128'd0);
        check("rst.mul_a", mul_a0, 128'd0);
        check("rst.add_a", add_a0, 128'd0);
        check("rst.busy1", busy1, 128'd0);
        rst = 1'b0;

        run_job("basic", A_1, B_1, C_1, 1'b0, 1'b0);
        run_job("signed", A_2, B_2, C_2, 1'b0, 1'b0);
        run_job("poke", A_2, B_2, C_2, 1'b1, 1'b0);
        run_job("latch", A_1, B_1, C_1, 1'b0, 1'b1);

        // Reset in the middle of MAC: abandon the job, no done afterwards.
        @(negedge clk);
        a0 = A_2;
        b0 = B_2;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", busy0, 128'd0);
        check("abort.done", done0, 128'd0);
        check("abort.result", res0, 128'd0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("abort.nodone", done0, 128'd0);
        end
        run_job("after_abort", A_2, B_2, C_2, 1'b0, 1'b0);

        // Start held high: a new job every 10 cycles, one done per job.
        @(negedge clk);
        a0 = A_1;
        b0 = B_1;
        start0 = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 20; n++) begin
            if (n > 0) @(negedge clk);
            check("held.busy", busy0, ((n % 10) != 9) ? 128'd1 : 128'd0);
            check("held.done", done0, ((n % 10) == 8) ? 128'd1 : 128'd0);
            if ((n % 10) == 8) check("held.result", res0, C_1);
        end
        start0 = 1'b0;

        // 1x3x2 instance: A=[1 2 3], B_T=[1 1 1; 0 -1 2] -> C=[6 4].
        @(negedge clk);
        a1 = {32'd3, 32'd2, 32'd1};
        b1 = {32'd2, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd1, 32'd1};
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) @(negedge clk);
            check("sweep.busy", busy1, (n <= 6) ? 128'd1 : 128'd0);
            check("sweep.done", done1, (n == 6) ? 128'd1 : 128'd0);
            if (n == 6) check("sweep.result", res1, {64'd0, 32'd4, 32'd6});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
